// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bus: the ID-stage operand fields and pipeline control
// requests going in, and the pipeline-register enables coming out.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              if_id_use_rs;
  logic              if_id_use_rt;
  logic [REG_AW-1:0] id_ex_rt;
  logic              id_ex_m;
  logic              pc_store;
  logic              if_id_write;
  logic              hazard_check;
  logic              id_ex_write;
  logic              ex_mem_write;
  logic              mem_wb_write;
  logic              bubble_active;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall, flush, if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt,
           id_ex_rt, id_ex_m,
    input  pc_store, if_id_write, hazard_check, id_ex_write, ex_mem_write,
           mem_wb_write, bubble_active, bubble_cnt
  );

  modport slave (
    input  stall, flush, if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt,
           id_ex_rt, id_ex_m,
    output pc_store, if_id_write, hazard_check, id_ex_write, ex_mem_write,
           mem_wb_write, bubble_active, bubble_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard and stall controller: multi-cycle bubbles for a configurable
// load latency, flush cancellation and a saturating bubble counter.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave hs
);
  localparam logic [2:0] REM_INIT = 3'(LOAD_LAT - 1);

  logic [2:0]        rem;
  logic [CNT_W-1:0]  cnt;
  logic [REG_AW-1:0] zero_reg;
  logic              rs_hit;
  logic              rt_hit;
  logic              new_hazard;
  logic              bubble;

  assign zero_reg   = '0;
  assign rs_hit     = hs.if_id_use_rs && (hs.if_id_rs == hs.id_ex_rt) && (hs.if_id_rs != zero_reg);
  assign rt_hit     = hs.if_id_use_rt && (hs.if_id_rt == hs.id_ex_rt) && (hs.if_id_rt != zero_reg);
  assign new_hazard = hs.id_ex_m && (rs_hit || rt_hit);

  // Freeze outranks flush, flush outranks pending bubbles, pending bubbles
  // outrank fresh detection (match is ignored while rem != 0).
  always_comb begin
    bubble = 1'b0;
    if (!hs.stall && !hs.flush)
      bubble = (rem != '0) || new_hazard;
  end

  assign hs.pc_store      = !hs.stall && !bubble;
  assign hs.if_id_write   = !hs.stall && !bubble;
  assign hs.hazard_check  = !hs.stall && !bubble;
  assign hs.id_ex_write   = !hs.stall;
  assign hs.ex_mem_write  = !hs.stall;
  assign hs.mem_wb_write  = !hs.stall;
  assign hs.bubble_active = bubble;
  assign hs.bubble_cnt    = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
      cnt <= '0;
    end else if (!hs.stall) begin
      if (hs.flush)
        rem <= '0;
      else if (rem != '0)
        rem <= rem - 3'd1;
      else if (new_hazard)
        rem <= REM_INIT;
      if (bubble && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl across LOAD_LAT = 1, 3, 4 and a 2-bit
// counter instance; all instances share stimulus but have separate resets.
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       rst1, rst3, rst4, rsts;
  logic       stall, flush, use_rs, use_rt, ex_m;
  logic [4:0] rs, rt, ex_rt;
  int         total = 0;
  int         bad   = 0;

  // {pc_store, if_id_write, hazard_check, id_ex_write, ex_mem_write, mem_wb_write, bubble_active}
  localparam logic [6:0] NORM = 7'b1111110;
  localparam logic [6:0] BUB  = 7'b0001111;
  localparam logic [6:0] FRZ  = 7'b0000000;

  logic [6:0] o1, o3, o4, os;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) if3 ();
  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) if4 ();
  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(2))  ifs ();

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .reset(rst1), .hs(if1));
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .reset(rst3), .hs(if3));
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(16)) u4 (.clk(clk), .reset(rst4), .hs(if4));
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2))  us (.clk(clk), .reset(rsts), .hs(ifs));

  assign {if1.stall, if1.flush, if1.if_id_rs, if1.if_id_rt, if1.if_id_use_rs, if1.if_id_use_rt, if1.id_ex_rt, if1.id_ex_m} = {stall, flush, rs, rt, use_rs, use_rt, ex_rt, ex_m};
  assign {if3.stall, if3.flush, if3.if_id_rs, if3.if_id_rt, if3.if_id_use_rs, if3.if_id_use_rt, if3.id_ex_rt, if3.id_ex_m} = {stall, flush, rs, rt, use_rs, use_rt, ex_rt, ex_m};
  assign {if4.stall, if4.flush, if4.if_id_rs, if4.if_id_rt, if4.if_id_use_rs, if4.if_id_use_rt, if4.id_ex_rt, if4.id_ex_m} = {stall, flush, rs, rt, use_rs, use_rt, ex_rt, ex_m};
  assign {ifs.stall, ifs.flush, ifs.if_id_rs, ifs.if_id_rt, ifs.if_id_use_rs, ifs.if_id_use_rt, ifs.id_ex_rt, ifs.id_ex_m} = {stall, flush, rs, rt, use_rs, use_rt, ex_rt, ex_m};

  assign o1 = {if1.pc_store, if1.if_id_write, if1.hazard_check, if1.id_ex_write, if1.ex_mem_write, if1.mem_wb_write, if1.bubble_active};
  assign o3 = {if3.pc_store, if3.if_id_write, if3.hazard_check, if3.id_ex_write, if3.ex_mem_write, if3.mem_wb_write, if3.bubble_active};
  assign o4 = {if4.pc_store, if4.if_id_write, if4.hazard_check, if4.id_ex_write, if4.ex_mem_write, if4.mem_wb_write, if4.bubble_active};
  assign os = {ifs.pc_store, ifs.if_id_write, ifs.hazard_check, ifs.id_ex_write, ifs.ex_mem_write, ifs.mem_wb_write, ifs.bubble_active};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load to r8 in EX, ID instruction reads r8 through rs.
  task automatic hazard(input logic on);
    ex_m   = on;
    ex_rt  = 5'd8;
    rs     = 5'd8;
    use_rs = on;
    rt     = 5'd0;
    use_rt = 1'b0;
  endtask

  initial begin
    {rst1, rst3, rst4, rsts} = 4'b1111;
    stall = 1'b0;
    flush = 1'b0;
    hazard(1'b0);
    #2;
    chk("rst_out", 16'(o1), 16'(NORM));
    chk("rst_cnt", if1.bubble_cnt, 16'd0);
    tick();
    tick();
    {rst1, rst3, rst4, rsts} = 4'b0000;
    #1;
    chk("idle_out", 16'(o1), 16'(NORM));
    chk("idle_cnt", if1.bubble_cnt, 16'd0);

    // LOAD_LAT = 1: single bubble
    hazard(1'b1);
    #1 chk("lu1_bub", 16'(o1), 16'(BUB));
    tick();
    hazard(1'b0);
    #1 chk("lu1_after", 16'(o1), 16'(NORM));
    chk("lu1_cnt", if1.bubble_cnt, 16'd1);
    tick();

    // exemptions: r0 never hazards, unused operand never hazards
    ex_m = 1'b1; ex_rt = 5'd0; rs = 5'd0; use_rs = 1'b1; rt = 5'd0; use_rt = 1'b1;
    #1 chk("zero_reg", 16'(o1), 16'(NORM));
    ex_rt = 5'd9; rs = 5'd9; rt = 5'd9; use_rs = 1'b0; use_rt = 1'b0;
    #1 chk("use_qual", 16'(o1), 16'(NORM));
    tick();
    chk("exempt_cnt", if1.bubble_cnt, 16'd1);
    use_rt = 1'b1;
    #1 chk("use_rt_hit", 16'(o1), 16'(BUB));
    flush = 1'b1;
    #1 chk("flush_supp", 16'(o1), 16'(NORM));
    stall = 1'b1;
    #1 chk("stall_frz", 16'(o1), 16'(FRZ));
    hazard(1'b0);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    chk("s1_cnt", if1.bubble_cnt, 16'd1);

    // LOAD_LAT = 3 with a 2-cycle freeze during the second bubble
    rst3 = 1'b1;
    #1 rst3 = 1'b0;
    hazard(1'b1);
    #1 chk("l3_b1", 16'(o3), 16'(BUB));
    tick();
    hazard(1'b0);
    #1 chk("l3_b2", 16'(o3), 16'(BUB));
    chk("l3_b2_cnt", if3.bubble_cnt, 16'd1);
    stall = 1'b1;
    #1 chk("l3_frz1", 16'(o3), 16'(FRZ));
    tick();
    chk("l3_frz2", 16'(o3), 16'(FRZ));
    chk("l3_frz_cnt", if3.bubble_cnt, 16'd1);
    tick();
    stall = 1'b0;
    #1 chk("l3_b2_resume", 16'(o3), 16'(BUB));
    tick();
    chk("l3_b3", 16'(o3), 16'(BUB));
    chk("l3_b3_cnt", if3.bubble_cnt, 16'd2);
    tick();
    chk("l3_done", 16'(o3), 16'(NORM));
    chk("l3_cnt", if3.bubble_cnt, 16'd3);
    hazard(1'b1);
    #1 chk("l3_no_dead", 16'(o3), 16'(BUB));
    hazard(1'b0);
    tick();

    // LOAD_LAT = 4, flush on second bubble
    rst4 = 1'b1;
    #1 rst4 = 1'b0;
    hazard(1'b1);
    #1 chk("l4_b1", 16'(o4), 16'(BUB));
    tick();
    hazard(1'b0);
    #1 chk("l4_b2", 16'(o4), 16'(BUB));
    flush = 1'b1;
    #1 chk("l4_flush", 16'(o4), 16'(NORM));
    tick();
    flush = 1'b0;
    #1 chk("l4_after_flush", 16'(o4), 16'(NORM));
    chk("l4_flush_cnt", if4.bubble_cnt, 16'd1);
    tick();
    chk("l4_no_more", 16'(o4), 16'(NORM));

    // LOAD_LAT = 4, reset on second bubble
    hazard(1'b1);
    #1 chk("l4r_b1", 16'(o4), 16'(BUB));
    tick();
    hazard(1'b0);
    #1 chk("l4r_b2", 16'(o4), 16'(BUB));
    chk("l4r_b2_cnt", if4.bubble_cnt, 16'd2);
    rst4 = 1'b1;
    #1 chk("l4r_rst_out", 16'(o4), 16'(NORM));
    chk("l4r_rst_cnt", if4.bubble_cnt, 16'd0);
    tick();
    rst4 = 1'b0;
    #1 chk("l4r_rel_out", 16'(o4), 16'(NORM));
    chk("l4r_rel_cnt", if4.bubble_cnt, 16'd0);
    tick();
    chk("l4r_no_more", 16'(o4), 16'(NORM));

    // 2-bit counter saturates at 3 over 5 separate hazards
    rsts = 1'b1;
    #1 rsts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hazard(1'b1);
      #1 chk("sat_bub", 16'(os), 16'(BUB));
      tick();
      hazard(1'b0);
      #1 chk("sat_cnt", 16'(ifs.bubble_cnt), (i < 3) ? 16'(i + 1) : 16'd3);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised load-use hazard and stall controller for the MIPS 5-stage pipeline; sits between the ID decode and the pipeline-register write enables.
- Generalises single-bubble load-use detection in four ways:
  - configurable load latency, giving multi-cycle bubbles from an internal counter;
  - per-operand use qualifiers and a hard-wired zero-register exemption;
  - flush cancellation of pending bubbles;
  - a saturating bubble performance counter.

Parameters:
- REG_AW, 5: register address width.
- LOAD_LAT, 1: bubbles required between a load in EX and a dependent instruction; legal range 1..8.
- CNT_W, 16: width of the bubble performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  global freeze (e.g. memory busy); freezes the whole pipeline.
- flush  input  1  taken branch/jump resolved; cancels any pending bubbles.
- if_id_rs  input  REG_AW  rs field of the instruction in ID.
- if_id_rt  input  REG_AW  rt field of the instruction in ID.
- if_id_use_rs  input  1  ID instruction reads rs.
- if_id_use_rt  input  1  ID instruction reads rt.
- id_ex_rt  input  REG_AW  destination of the instruction in EX.
- id_ex_m  input  1  instruction in EX is a load (MemRead).
- pc_store  output  1  PC write enable.
- if_id_write  output  1  IF/ID register write enable.
- hazard_check  output  1  1 = pass ID control signals; 0 = zero them (bubble).
- id_ex_write  output  1  ID/EX write enable.
- ex_mem_write  output  1  EX/MEM write enable.
- mem_wb_write  output  1  MEM/WB write enable.
- bubble_active  output  1  a bubble is inserted this cycle.
- bubble_cnt  output  CNT_W  total bubbles inserted; saturates at all-ones.

Behaviour:
- State:
  - rem: remaining extra bubbles, 3 bits.
  - bubble_cnt.
  - Both clear to 0 asynchronously while reset=1.
- Outputs are combinational from the inputs and rem.
- Outputs during reset:
  - Follow the same priority rules with rem=0.
  - Reset with stall=0 and no hazard gives all enables and hazard_check = 1, bubble_active = 0, bubble_cnt = 0.
  - Reset asserted mid-sequence aborts it immediately.
- match is true when either condition holds:
  - if_id_use_rs and if_id_rs == id_ex_rt and if_id_rs != 0;
  - if_id_use_rt and if_id_rt == id_ex_rt and if_id_rt != 0.
- Priority, highest first:
  1. stall=1 (freeze): all six enables 0. rem and bubble_cnt hold. bubble_active = 0.
  2. flush=1: all enables 1, hazard_check = 1. rem <= 0 at the next edge. Detection is suppressed (the ID instruction is being squashed).
  3. rem != 0 (bubble): pc_store = 0, if_id_write = 0, hazard_check = 0; id_ex_write, ex_mem_write and mem_wb_write = 1. rem <= rem - 1.
  4. id_ex_m and match (new hazard): same outputs as the bubble case. rem <= LOAD_LAT - 1.
  5. Otherwise (normal): all enables 1, hazard_check = 1.
- bubble_active = 1 exactly in cases 3 and 4.
- On each such edge, bubble_cnt <= bubble_cnt + 1 unless already all-ones (saturating, no wrap).
- Latency:
  - Detection is same-cycle (combinational).
  - A hazard yields exactly LOAD_LAT consecutive non-frozen bubble cycles.
  - Frozen cycles interleaved with bubbles do not consume bubbles.
- LOAD_LAT = 1: rem never leaves 0, so the block behaves as a single-bubble load-use detector.
- While rem != 0, match is not evaluated. The ID instruction is held and EX holds a bubble.
- A new hazard arising on the cycle after rem reaches 0 is detected normally; there is no dead cycle.

Test Plan:
- Reset then idle:
  - Stimulus: reset pulse, then stall = 0, id_ex_m = 0.
  - Required: all enables 1, hazard_check = 1, bubble_cnt = 0.
- Basic hazard, LOAD_LAT = 1:
  - Stimulus: id_ex_m = 1, id_ex_rt = 8, if_id_rs = 8, use_rs = 1, for one cycle.
  - Required: one cycle with pc_store = if_id_write = hazard_check = 0 and id_ex_write = 1; bubble_cnt = 1.
- Zero-register and use-qualifier exemption:
  - Stimulus A: id_ex_rt = 0 with if_id_rs = 0.
  - Stimulus B: id_ex_rt = 9 with if_id_rt = 9, use_rt = 0.
  - Required in both cases: no bubble.
- Multi-cycle bubbles, LOAD_LAT = 3:
  - Stimulus: hazard detected, with stall = 1 asserted for 2 cycles during the second bubble.
  - Required: exactly 3 bubble cycles, all enables 0 during the freeze, bubble_cnt = 3.
- Flush and reset abort, LOAD_LAT = 4:
  - Stimulus: hazard, then flush on the second bubble.
  - Required: normal outputs that cycle, no further bubbles.
  - Repeat with reset asserted on the second bubble instead; required: rem = 0, bubble_cnt = 0.
- Saturation, CNT_W = 2:
  - Stimulus: 5 separate hazards.
  - Required: bubble_cnt stops at 3.
